// File: rtl/mem_arb_pkg.sv
// Shared types and grant-priority helper for mem_port_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

   localparam logic [3:0] BYTE_EN_ALL = 4'hF;

   // On a tie the requester that did not win last time gets the port.
   function automatic grant_t pick(input logic i_req, input logic d_req, input grant_t last_grant);
      if (i_req && d_req) begin
         return (last_grant == GNT_D) ? GNT_I : GNT_D;
      end else if (i_req) begin
         return GNT_I;
      end else begin
         return GNT_D;
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data requesters, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed data priority with alternating tie-break.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic [DATA_W-1:0]     i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [DATA_W/8-1:0]   d_mbe,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_W/8-1:0]   mem_byte_enable,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_resp,
   output logic                  busy
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t          state_q, state_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [BE_W-1:0]     mem_be_q, mem_be_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                any_req;
   logic                d_req;
   grant_t              gnt;
   grant_t              last_grant_eff;
   logic                unused_addr_bits;

`ifdef ARB_ROUND_ROBIN_EN
   grant_t              last_grant_q, last_grant_d;
   assign last_grant_eff = last_grant_q;
`else
   assign last_grant_eff = GNT_I;
`endif

   assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

   assign d_req   = d_read | d_write;
   assign any_req = i_read | d_req;
   assign gnt     = pick(i_read, d_req, last_grant_eff);

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = gnt;
`endif
               if (gnt == GNT_D) begin
                  // A simultaneous read and write is treated as a write only.
                  state_d     = D_BUSY;
                  mem_write_d = d_write;
                  mem_read_d  = ~d_write;
                  mem_be_d    = d_write ? d_mbe : {BE_W{1'b1}};
                  mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = d_wdata;
               end else begin
                  state_d     = I_BUSY;
                  mem_write_d = 1'b0;
                  mem_read_d  = 1'b1;
                  mem_be_d    = {BE_W{1'b1}};
                  mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = '0;
               end
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_resp) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= GNT_I;
`endif
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_byte_enable = mem_be_q;
   assign mem_address     = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign busy            = (state_q != IDLE);

   // Completion is a same-cycle pass-through of the memory response to the current owner.
   assign i_resp  = (state_q == I_BUSY) && mem_resp;
   assign d_resp  = (state_q == D_BUSY) && mem_resp;
   assign i_rdata = i_resp ? mem_rdata : '0;
   assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [3:0]  d_mbe;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        busy;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_mbe(d_mbe), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        i_rd;
      logic        d_rd;
      logic        d_wr;
      logic [31:0] ia;
      logic [31:0] da;
      logic [3:0]  mbe;
      logic [31:0] wd;
      logic [31:0] rdi;
      logic [31:0] rdd;
      int          dly;
      int          ntxn;
   } vec_t;

   typedef struct {
      logic        is_i;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   vec_t   tbl[5];
   exp_t   sb[$];
   grant_t lg_model;
   int     checks = 0;
   int     failures = 0;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, req);
      end
   endtask

   task automatic predict();
      exp_t   e;
      grant_t g;
`ifdef ARB_ROUND_ROBIN_EN
      g = pick(i_read, d_read | d_write, lg_model);
      lg_model = g;
`else
      g = pick(i_read, d_read | d_write, GNT_I);
`endif
      e.is_i = (g == GNT_I);
      if (e.is_i) begin
         e.wr    = 1'b0;
         e.addr  = {i_addr[31:2], 2'b00};
         e.be    = BYTE_EN_ALL;
         e.wdata = 32'h0;
      end else begin
         e.wr    = d_write;
         e.addr  = {d_addr[31:2], 2'b00};
         e.be    = d_write ? d_mbe : BYTE_EN_ALL;
         e.wdata = d_wdata;
      end
      sb.push_back(e);
   endtask

   task automatic serve(input int dly, input logic [31:0] rdi, input logic [31:0] rdd,
                        output logic won_i);
      exp_t        e;
      logic        stable;
      logic [31:0] rd;
      won_i = 1'b0;
      if (sb.size() == 0) begin
         chk1("scoreboard_empty", 1'b1, 1'b0);
         return;
      end
      e  = sb.pop_front();
      rd = e.is_i ? rdi : rdd;
      @(posedge clk); #1;
      chk1("busy_grant", busy, 1'b1);
      chk1("mem_read", mem_read, ~e.wr);
      chk1("mem_write", mem_write, e.wr);
      chk32("mem_byte_enable", 32'(mem_byte_enable), 32'(e.be));
      chk32("mem_address", mem_address, e.addr);
      if (e.wr) chk32("mem_wdata", mem_wdata, e.wdata);
      stable = 1'b1;
      for (int k = 0; k < dly; k++) begin
         @(posedge clk); #1;
         if (mem_read !== ~e.wr || mem_write !== e.wr || mem_byte_enable !== e.be ||
             mem_address !== e.addr || (e.wr && mem_wdata !== e.wdata))
            stable = 1'b0;
      end
      chk1("mem_hold", stable, 1'b1);
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = rd;
      #1;
      chk1("i_resp", i_resp, e.is_i);
      chk1("d_resp", d_resp, ~e.is_i);
      chk32("i_rdata", i_rdata, e.is_i ? rd : 32'h0);
      chk32("d_rdata", d_rdata, e.is_i ? 32'h0 : rd);
      won_i = i_resp;
      @(posedge clk); #1;
      chk1("resp_one_cycle", i_resp | d_resp, 1'b0);
      chk1("busy_after_resp", busy, 1'b0);
      chk1("strobes_after_resp", mem_read | mem_write, 1'b0);
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      if (e.is_i) i_read = 1'b0;
      else begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      mem_resp = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      lg_model = GNT_I;
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic won;
      logic won_seq[3];
      logic exp_seq[3];

      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0062, 32'h0, 4'h0, 32'h0, 32'h0000_0013, 32'h0, 2, 1};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 4'h3, 32'hDEAD_BEEF, 32'h0, 32'h0, 5, 1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0000_0308, 4'h0, 32'h0, 32'hAAAA_5555, 32'h1234_5678, 1, 2};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_040B, 4'hC, 32'h0BAD_F00D, 32'h0, 32'h0000_0077, 0, 1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_07F3, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1};
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0;
`else
      exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
`endif

      rst = 1'b1;
      i_read = 1'b0; i_addr = 32'h0;
      d_read = 1'b0; d_write = 1'b0; d_mbe = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      mem_rdata = 32'h0; mem_resp = 1'b0;
      lg_model = GNT_I;
      do_reset();

      #1;
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_mem_read", mem_read, 1'b0);
      chk1("reset_mem_write", mem_write, 1'b0);
      chk32("reset_mem_be", 32'(mem_byte_enable), 32'h0);
      chk32("reset_mem_address", mem_address, 32'h0);
      chk32("reset_mem_wdata", mem_wdata, 32'h0);
      chk1("reset_resps", i_resp | d_resp, 1'b0);

      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         i_read  = tbl[n].i_rd;
         d_read  = tbl[n].d_rd;
         d_write = tbl[n].d_wr;
         i_addr  = tbl[n].ia;
         d_addr  = tbl[n].da;
         d_mbe   = tbl[n].mbe;
         d_wdata = tbl[n].wd;
         predict();
         serve(tbl[n].dly, tbl[n].rdi, tbl[n].rdd, won);
         if (tbl[n].ntxn == 2) begin
            predict();
            serve(tbl[n].dly, tbl[n].rdi, tbl[n].rdd, won);
         end
         repeat (3) @(posedge clk);
         #1;
         chk1("no_extra_txn", mem_read | mem_write | busy, 1'b0);
      end

      // Stray memory response while idle.
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = 32'h5A5A_5A5A;
      #1;
      chk1("stray_i_resp", i_resp, 1'b0);
      chk1("stray_d_resp", d_resp, 1'b0);
      chk32("stray_i_rdata", i_rdata, 32'h0);
      chk32("stray_d_rdata", d_rdata, 32'h0);
      @(posedge clk); #1;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      chk1("stray_busy", busy, 1'b0);

      // Reset while a data write is in flight.
      @(negedge clk);
      d_write = 1'b1; d_addr = 32'h0000_0500; d_mbe = 4'hF; d_wdata = 32'h0000_0001;
      @(posedge clk); #1;
      chk1("midflight_write_started", mem_write, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk1("midflight_mem_write", mem_write, 1'b0);
      chk1("midflight_mem_read", mem_read, 1'b0);
      chk1("midflight_busy", busy, 1'b0);
      rst = 1'b0;
      d_write = 1'b0;
      lg_model = GNT_I;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = 32'h1111_2222;
      #1;
      chk1("late_resp_d_resp", d_resp, 1'b0);
      chk1("late_resp_i_resp", i_resp, 1'b0);
      @(posedge clk); #1;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      chk1("late_resp_busy", busy, 1'b0);

      // Three consecutive ties with both requesters re-requesting at once.
      @(negedge clk);
      i_read = 1'b1; i_addr = 32'h0000_0A00;
      d_read = 1'b1; d_addr = 32'h0000_0B00; d_write = 1'b0;
      for (int r = 0; r < 3; r++) begin
         predict();
         serve(0, 32'h100 + 32'(r), 32'h200 + 32'(r), won);
         won_seq[r] = won;
         i_read = 1'b1;
         d_read = 1'b1;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      for (int r = 0; r < 3; r++) chk1("tie_order", won_seq[r], exp_seq[r]);
      repeat (2) @(posedge clk);
      #1;
      chk1("tie_end_idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
